mcb_dat_seq: RTL and testbench
==============================

// Module: mcb_dat_seq
// PURPOSE
//  Data-phase sequencer for the sdrc_lite back-end. Driven by the command engine (WRITE/READ issue
//  strobes); generates the MCB_DAT_FF controls d_wr_ld, d_dp_oe, d_dp_ie and the MCB-side beat
//  strobes. Handles CAS latency, burst length and pipelined reads. Flags illegal overlaps.
// PARAMETERS
//  CL_MAX   3  largest supported CAS latency (cycles)
//  RD_PIPE  1  extra input-register stages between SDR DQ pins and the data FF capture point
//  BL_MAX   8  largest burst length; sets read-pipe depth = CL_MAX+RD_PIPE+BL_MAX
// PORTS
//  mcb_clk     in   1  controller clock
//  mcb_rst_n   in   1  reset, asynchronous, active-low
//  mcb_sclr_n  in   1  synchronous clear, active-low; same effect as reset on the next edge
//  c_cas_lat   in   2  CAS latency 1..3; 0 treated as 1; sampled at read start
//  c_bl        in   2  burst length code 0=1,1=2,2=4,3=8; sampled at burst start
//  c_wr_pre    in   1  pulse: WRITE command goes on the SDR bus 2 cycles later
//  c_rd_go     in   1  pulse: READ command is on the SDR bus this cycle
//  d_wr_ld     out  1  load next write beat from mcb_wdat/mcb_wbe into the data FF
//  d_dp_oe     out  1  drive DQ with the data FF contents
//  d_dp_ie     out  1  capture a read beat from DQ
//  mcb_wack    out  1  one write beat consumed from MCB (equals d_wr_ld)
//  mcb_rvld    out  1  mcb_rdat holds a valid read beat (d_dp_ie delayed 1 cycle)
//  i_ready     out  1  data path idle; command engine may start any burst
//  dp_err      out  1  sticky protocol-violation flag
// BEHAVIOUR
//  - All outputs registered. Reset/sclr: d_wr_ld=d_dp_oe=d_dp_ie=mcb_wack=mcb_rvld=dp_err=0, i_ready=1,
//    read pipe cleared, write counter idle. Reset mid-burst drops all strobes immediately (async).
//  - BL = 1<<c_bl. Write: c_wr_pre in cycle T -> d_wr_ld/mcb_wack high T+1..T+BL, d_dp_oe high
//    T+2..T+BL+1. The write burst is active from T+1 through T+BL+1.
//  - Write FSM: IDLE -> LOAD (first d_wr_ld cycle) -> STREAM (d_wr_ld & d_dp_oe, BL-1 cycles)
//    -> DRAIN (d_dp_oe only, 1 cycle) -> IDLE. BL=1: LOAD -> DRAIN. Beat counter 3 bits, counts down.
//  - Read: c_rd_go in cycle T -> d_dp_ie high T+CL+RD_PIPE .. T+CL+RD_PIPE+BL-1;
//    mcb_rvld high one cycle later for the same count. Implemented as a beat-valid shift register:
//    on accept, set bits at offset CL+RD_PIPE-1 .. +BL-1; shift one position per cycle.
//  - i_ready=0 while a write burst is active, any read-pipe bit is set, or mcb_rvld=1; else 1.
//  - Reads pipeline: c_rd_go accepted while earlier reads are pending if its beat bits do not overlap
//    set bits (contiguous back-to-back allowed). Overlap -> dp_err=1, new read ignored.
//  - c_wr_pre while a write is active or any read pending -> dp_err=1, ignored.
//  - c_rd_go while a write burst is active -> dp_err=1, ignored.
//  - c_wr_pre and c_rd_go in the same cycle -> dp_err=1, both ignored.
//  - dp_err cleared only by mcb_rst_n or mcb_sclr_n. c_cas_lat and c_bl changes mid-burst do not
//    affect bursts already accepted.
// STRUCTURE
//  - Shared package (SDRC_LITE_MCB_PAR): CL_MAX, RD_PIPE, BL_MAX, c_bl code encodings,
//    write FSM state encodings.
//  - Sub-module mcb_rd_pipe: beat-valid shift register with overlap-check and insert port.
//    Write FSM and i_ready/dp_err logic live in the top level.
// TESTING
//  1. Reset pulse, no commands -> all strobes 0, i_ready=1, dp_err=0.
//  2. c_bl=2, c_wr_pre at cycle 10 -> d_wr_ld 11-14, d_dp_oe 12-15, i_ready 0 for 11-15, 1 at 16.
//  3. CL=3, RD_PIPE=1, c_bl=2, c_rd_go at 20 -> d_dp_ie 24-27, mcb_rvld 25-28, i_ready 1 at 29.
//  4. CL=2, c_bl=1, c_rd_go at 30 and 32 -> d_dp_ie 33-36 contiguous, dp_err=0;
//     repeat with c_rd_go at 30 and 31 -> dp_err=1, d_dp_ie only 33-34.
//  5. c_wr_pre and c_rd_go both at 40 -> no strobes, dp_err=1; mcb_sclr_n low at 45 -> dp_err 0 at 46.
//  6. c_bl=3 write, mcb_rst_n low during third d_dp_oe beat -> all strobes 0 at once, i_ready=1.

Source files
------------

// File: rtl/mcb_dat_seq_pkg.sv
// rtl/mcb_dat_seq_pkg.sv - shared parameters, encodings and helpers for the MCB data-phase sequencer
package mcb_dat_seq_pkg;

  localparam int CL_MAX   = 3;
  localparam int RD_PIPE  = 1;
  localparam int BL_MAX   = 8;
  localparam int RP_DEPTH = CL_MAX + RD_PIPE + BL_MAX;

  typedef enum logic [1:0] {
    BL_1 = 2'd0,
    BL_2 = 2'd1,
    BL_4 = 2'd2,
    BL_8 = 2'd3
  } bl_code_e;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_LOAD   = 2'd1,
    WR_STREAM = 2'd2,
    WR_DRAIN  = 2'd3
  } wr_state_e;

  function automatic logic [3:0] bl_len(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

endpackage

// File: rtl/mcb_dat_seq_if.sv
// rtl/mcb_dat_seq_if.sv - command-engine / data-path strobe bundle for the MCB data-phase sequencer
interface mcb_dat_seq_if;

  logic [1:0] c_cas_lat;
  logic [1:0] c_bl;
  logic       c_wr_pre;
  logic       c_rd_go;
  logic       d_wr_ld;
  logic       d_dp_oe;
  logic       d_dp_ie;
  logic       mcb_wack;
  logic       mcb_rvld;
  logic       i_ready;
  logic       dp_err;

  modport master (
    output c_cas_lat, c_bl, c_wr_pre, c_rd_go,
    input  d_wr_ld, d_dp_oe, d_dp_ie, mcb_wack, mcb_rvld, i_ready, dp_err
  );

  modport slave (
    input  c_cas_lat, c_bl, c_wr_pre, c_rd_go,
    output d_wr_ld, d_dp_oe, d_dp_ie, mcb_wack, mcb_rvld, i_ready, dp_err
  );

endinterface

// File: rtl/mcb_dat_seq_rd_pipe.sv
// rtl/mcb_dat_seq_rd_pipe.sv - read beat-valid shift register with overlap check and burst insert
module mcb_rd_pipe
  import mcb_dat_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclr_n,
  input  logic       ins,
  input  logic [1:0] cas_lat,
  input  logic [1:0] bl,
  output logic       ovl,
  output logic       pend,
  output logic       pend_nxt,
  output logic       ie
);

  logic [RP_DEPTH-1:0] bits;
  logic [RP_DEPTH-1:0] shifted;
  logic [RP_DEPTH-1:0] base;
  logic [RP_DEPTH-1:0] mask;
  logic [1:0]          cl_eff;

  // Bit k of the register (after the shift) means "capture a beat k+1 cycles from now".
  always_comb begin
    cl_eff  = (cas_lat == 2'd0) ? 2'd1 : cas_lat;
    base    = (RP_DEPTH'(1) << bl_len(bl)) - RP_DEPTH'(1);
    mask    = base << (cl_eff + RD_PIPE - 1);
    shifted = bits >> 1;
  end

  assign ovl      = |(shifted & mask);
  assign pend     = |bits;
  assign pend_nxt = |(ins ? (shifted | mask) : shifted);
  assign ie       = bits[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
    end else if (!sclr_n) begin
      bits <= '0;
    end else begin
      bits <= ins ? (shifted | mask) : shifted;
    end
  end

endmodule

// File: rtl/mcb_dat_seq.sv
// rtl/mcb_dat_seq.sv - data-phase sequencer: write burst FSM, read pipe, ready and protocol-error flags
module mcb_dat_seq
  import mcb_dat_seq_pkg::*;
(
  input  logic          mcb_clk,
  input  logic          mcb_rst_n,
  input  logic          mcb_sclr_n,
  mcb_dat_seq_if.slave  bus
);

  wr_state_e  state;
  logic [2:0] beat_cnt;
  logic       rd_ovl;
  logic       rd_pend;
  logic       rd_pend_nxt;
  logic       rd_ie;
  logic       wr_busy;
  logic       wr_busy_nxt;
  logic       wr_ok;
  logic       rd_ok;
  logic       cmd_err;

  // Any command that is not accepted is a protocol violation, including a simultaneous pair.
  assign wr_busy     = (state != WR_IDLE);
  assign wr_ok       = bus.c_wr_pre && !bus.c_rd_go && !wr_busy && !rd_pend;
  assign rd_ok       = bus.c_rd_go && !bus.c_wr_pre && !wr_busy && !rd_ovl;
  assign cmd_err     = (bus.c_wr_pre || bus.c_rd_go) && !wr_ok && !rd_ok;
  assign wr_busy_nxt = wr_ok || (state == WR_LOAD) || (state == WR_STREAM);

  mcb_rd_pipe u_rd_pipe (
    .clk      (mcb_clk),
    .rst_n    (mcb_rst_n),
    .sclr_n   (mcb_sclr_n),
    .ins      (rd_ok),
    .cas_lat  (bus.c_cas_lat),
    .bl       (bus.c_bl),
    .ovl      (rd_ovl),
    .pend     (rd_pend),
    .pend_nxt (rd_pend_nxt),
    .ie       (rd_ie)
  );

  assign bus.d_dp_ie = rd_ie;

  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      state        <= WR_IDLE;
      beat_cnt     <= '0;
      bus.d_wr_ld  <= 1'b0;
      bus.mcb_wack <= 1'b0;
      bus.d_dp_oe  <= 1'b0;
      bus.mcb_rvld <= 1'b0;
      bus.i_ready  <= 1'b1;
      bus.dp_err   <= 1'b0;
    end else if (!mcb_sclr_n) begin
      state        <= WR_IDLE;
      beat_cnt     <= '0;
      bus.d_wr_ld  <= 1'b0;
      bus.mcb_wack <= 1'b0;
      bus.d_dp_oe  <= 1'b0;
      bus.mcb_rvld <= 1'b0;
      bus.i_ready  <= 1'b1;
      bus.dp_err   <= 1'b0;
    end else begin
      bus.mcb_rvld <= rd_ie;
      bus.i_ready  <= !(wr_busy_nxt || rd_pend_nxt || rd_ie);
      bus.dp_err   <= bus.dp_err | cmd_err;
      // beat_cnt holds the number of load beats still to come after the current one
      case (state)
        WR_IDLE: begin
          if (wr_ok) begin
            state        <= WR_LOAD;
            beat_cnt     <= 3'(bl_len(bus.c_bl) - 4'd1);
            bus.d_wr_ld  <= 1'b1;
            bus.mcb_wack <= 1'b1;
            bus.d_dp_oe  <= 1'b0;
          end
        end
        WR_LOAD, WR_STREAM: begin
          bus.d_dp_oe <= 1'b1;
          if (beat_cnt == 3'd0) begin
            state        <= WR_DRAIN;
            bus.d_wr_ld  <= 1'b0;
            bus.mcb_wack <= 1'b0;
          end else begin
            state    <= WR_STREAM;
            beat_cnt <= beat_cnt - 3'd1;
          end
        end
        WR_DRAIN: begin
          state       <= WR_IDLE;
          bus.d_dp_oe <= 1'b0;
        end
        default: begin
          state        <= WR_IDLE;
          bus.d_wr_ld  <= 1'b0;
          bus.mcb_wack <= 1'b0;
          bus.d_dp_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcb_dat_seq.sv
// tb/tb_mcb_dat_seq.sv - table-driven self-checking bench for mcb_dat_seq
module tb_mcb_dat_seq;

  logic mcb_clk = 1'b0;
  logic mcb_rst_n;
  logic mcb_sclr_n;

  mcb_dat_seq_if bus ();

  mcb_dat_seq dut (
    .mcb_clk    (mcb_clk),
    .mcb_rst_n  (mcb_rst_n),
    .mcb_sclr_n (mcb_sclr_n),
    .bus        (bus)
  );

  always #5 mcb_clk = ~mcb_clk;

  // exp = {d_wr_ld, d_dp_oe, d_dp_ie, mcb_rvld, i_ready, dp_err}; mcb_wack must equal d_wr_ld
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [1:0] cl;
    logic [1:0] bl;
    logic       sclr_n;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int wr, input int rd, input int cl, input int bl, input int sc,
                     input logic [5:0] exp);
    vec_t v;
    v.wr     = (wr != 0);
    v.rd     = (rd != 0);
    v.cl     = 2'(cl);
    v.bl     = 2'(bl);
    v.sclr_n = (sc != 0);
    v.exp    = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [6:0] outs();
    return {bus.d_wr_ld, bus.d_dp_oe, bus.d_dp_ie, bus.mcb_rvld, bus.i_ready, bus.dp_err,
            bus.mcb_wack};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b (ld oe ie rvld rdy err wack)", name, act, req);
    end
  endtask

  task automatic drive_idle();
    bus.c_wr_pre  = 1'b0;
    bus.c_rd_go   = 1'b0;
    bus.c_cas_lat = 2'd3;
    bus.c_bl      = 2'd0;
  endtask

  initial begin
    // write BL=4, then BL=1 (LOAD straight to DRAIN)
    add(0,0,3,2,1,6'b000010); add(0,0,3,2,1,6'b000010);
    add(1,0,3,2,1,6'b000010); add(0,0,3,2,1,6'b100000); add(0,0,3,2,1,6'b110000);
    add(0,0,3,2,1,6'b110000); add(0,0,3,2,1,6'b110000); add(0,0,3,2,1,6'b010000);
    add(0,0,3,2,1,6'b000010);
    add(1,0,3,0,1,6'b000010); add(0,0,3,0,1,6'b100000); add(0,0,3,0,1,6'b010000);
    add(0,0,3,0,1,6'b000010);
    // read CL=3 BL=4
    add(0,1,3,2,1,6'b000010); add(0,0,3,2,1,6'b000000); add(0,0,3,2,1,6'b000000);
    add(0,0,3,2,1,6'b000000); add(0,0,3,2,1,6'b001000); add(0,0,3,2,1,6'b001100);
    add(0,0,3,2,1,6'b001100); add(0,0,3,2,1,6'b001100); add(0,0,3,2,1,6'b000100);
    add(0,0,3,2,1,6'b000010);
    // read with CAS code 0 (treated as 1), BL=1
    add(0,1,0,0,1,6'b000010); add(0,0,0,0,1,6'b000000); add(0,0,0,0,1,6'b001000);
    add(0,0,0,0,1,6'b000100); add(0,0,0,0,1,6'b000010);
    // CL=2 BL=2 back-to-back contiguous reads
    add(0,1,2,1,1,6'b000010); add(0,0,2,1,1,6'b000000); add(0,1,2,1,1,6'b000000);
    add(0,0,2,1,1,6'b001000); add(0,0,2,1,1,6'b001100); add(0,0,2,1,1,6'b001100);
    add(0,0,2,1,1,6'b001100); add(0,0,2,1,1,6'b000100); add(0,0,2,1,1,6'b000010);
    // overlapping second read is rejected
    add(0,1,2,1,1,6'b000010); add(0,1,2,1,1,6'b000000); add(0,0,2,1,1,6'b000001);
    add(0,0,2,1,1,6'b001001); add(0,0,2,1,1,6'b001101); add(0,0,2,1,1,6'b000101);
    add(0,0,2,1,1,6'b000011);
    add(0,0,2,1,0,6'b000011); add(0,0,2,1,1,6'b000010);
    // simultaneous write and read, then synchronous clear
    add(1,1,2,1,1,6'b000010); add(0,0,2,1,1,6'b000011); add(0,0,2,1,1,6'b000011);
    add(0,0,2,1,0,6'b000011); add(0,0,2,1,1,6'b000010);
    // read during write burst is rejected
    add(1,0,1,1,1,6'b000010); add(0,1,1,1,1,6'b100000); add(0,0,1,1,1,6'b110001);
    add(0,0,1,1,1,6'b010001); add(0,0,1,1,1,6'b000011); add(0,0,1,1,1,6'b000011);
    add(0,0,1,1,0,6'b000011); add(0,0,1,1,1,6'b000010);
    // write while a read is pending is rejected
    add(0,1,1,0,1,6'b000010); add(1,0,1,0,1,6'b000000); add(0,0,1,0,1,6'b001001);
    add(0,0,1,0,1,6'b000101); add(0,0,1,0,1,6'b000011);
    add(0,0,1,0,0,6'b000011); add(0,0,1,0,1,6'b000010);
    // c_bl change mid-burst keeps the accepted BL=2
    add(1,0,1,1,1,6'b000010); add(0,0,1,3,1,6'b100000); add(0,0,1,3,1,6'b110000);
    add(0,0,1,3,1,6'b010000); add(0,0,1,3,1,6'b000010);

    drive_idle();
    mcb_sclr_n = 1'b1;
    mcb_rst_n  = 1'b0;
    repeat (3) @(negedge mcb_clk);
    chk("reset_state", outs(), 7'b0000100);
    mcb_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge mcb_clk);
      chk($sformatf("row%0d", i), outs(), {vecs[i].exp, vecs[i].exp[5]});
      bus.c_wr_pre  = vecs[i].wr;
      bus.c_rd_go   = vecs[i].rd;
      bus.c_cas_lat = vecs[i].cl;
      bus.c_bl      = vecs[i].bl;
      mcb_sclr_n    = vecs[i].sclr_n;
    end

    // BL=8 write, async reset during the third d_dp_oe beat
    @(negedge mcb_clk);
    mcb_sclr_n   = 1'b1;
    bus.c_wr_pre = 1'b1;
    bus.c_bl     = 2'd3;
    @(negedge mcb_clk);
    bus.c_wr_pre = 1'b0;
    chk("bl8_first_load", outs(), 7'b1000001);
    repeat (3) @(negedge mcb_clk);
    chk("bl8_third_oe", outs(), 7'b1100001);
    mcb_rst_n = 1'b0;
    #1;
    chk("async_reset_drop", outs(), 7'b0000100);
    @(negedge mcb_clk);
    chk("reset_held", outs(), 7'b0000100);
    mcb_rst_n = 1'b1;
    repeat (2) @(negedge mcb_clk);
    chk("after_reset_idle", outs(), 7'b0000100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
